// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, FSM states,
// instruction field positions and small decode helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_OR      = 4'd2;
    localparam logic [3:0] OP_AND     = 4'd3;
    localparam logic [3:0] OP_SLT     = 4'd4;
    localparam logic [3:0] OP_SHL     = 4'd5;
    localparam logic [3:0] OP_SHR     = 4'd6;
    localparam logic [3:0] OP_ADDI    = 4'd7;
    localparam logic [3:0] OP_SUBI    = 4'd8;
    localparam logic [3:0] OP_CMP     = 4'd9;
    localparam logic [3:0] OP_NOP_ALU = 4'd15;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic is_illegal(input logic [3:0] opc);
        return opc > OP_CMP;
    endfunction

    function automatic logic is_imm(input logic [3:0] opc);
        return (opc == OP_ADDI) || (opc == OP_SUBI);
    endfunction

    function automatic logic writes_back(input logic [3:0] opc);
        return opc < OP_CMP;
    endfunction

    // CMP reuses the subtractor; illegal opcodes select the ALU's zero-output op.
    function automatic logic [3:0] map_op(input logic [3:0] opc);
        if (opc == OP_CMP) begin
            return OP_SUB;
        end else if (is_illegal(opc)) begin
            return OP_NOP_ALU;
        end
        return opc;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two operand read ports, a debug read port and
// one synchronous write port. R0 is hardwired to zero.
module alu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];
    assign dbg_data  = (dbg_addr  == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Four-state issue/writeback sequencer feeding a combinational 16-bit ALU,
// one instruction in flight at a time.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic              illegal,
    output logic              zero_flag,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    state_t            state_next;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] res_q;
    logic              zq;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [3:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [2:0]        rt;
    logic [3:0]        imm4;
    logic              wr_en;

    assign opcode = instr_q[OPC_MSB:OPC_LSB];
    assign rd     = instr_q[RD_MSB:RD_LSB];
    assign rs     = instr_q[RS_MSB:RS_LSB];
    assign rt     = instr_q[RT_MSB:RT_LSB];
    assign imm4   = instr_q[IMM_MSB:IMM_LSB];

    assign instr_ready = (state == ST_IDLE) && !rst;
    assign done        = (state == ST_WB) && !rst;
    assign illegal     = done && is_illegal(opcode);
    assign wr_en       = (state == ST_WB) && writes_back(opcode) && (rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (instr_valid) state_next = ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ALU inputs are registered once in READ so they stay stable through EXEC,
    // WB and the following IDLE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_q     <= '0;
            zq        <= 1'b0;
            zero_flag <= 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                instr_q <= instr;
            end
            if (state == ST_READ) begin
                alu_a  <= rs_data;
                alu_b  <= is_imm(opcode) ? {{(DATA_W-4){1'b0}}, imm4} : rt_data;
                alu_op <= map_op(opcode);
            end
            if (state == ST_EXEC) begin
                res_q <= alu_result;
                zq    <= alu_zero;
            end
            if ((state == ST_WB) && (opcode == OP_CMP)) begin
                zero_flag <= zq;
            end
        end
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (rd),
        .wr_data   (res_q),
        .rd_addr_a (rs),
        .rd_data_a (rs_data),
        .rd_addr_b (rt),
        .rd_data_b (rt_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural ALU in the loop and
// hand-computed expected values.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        done;
    logic        illegal;
    logic        zero_flag;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .done        (done),
        .illegal     (illegal),
        .zero_flag   (zero_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Stand-in for the downstream ALU
    always_comb begin
        alu_result = 16'd0;
        case (alu_op)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a | alu_b;
            4'd3: alu_result = alu_a & alu_b;
            4'd4: alu_result = {15'd0, $signed(alu_a) < $signed(alu_b)};
            4'd5: alu_result = alu_a << alu_b[3:0];
            4'd6: alu_result = alu_a >> alu_b[3:0];
            4'd7: alu_result = alu_a + alu_b;
            4'd8: alu_result = alu_a - alu_b;
            default: alu_result = 16'd0;
        endcase
        alu_zero = (alu_result == 16'd0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkReg(input string tag, input logic [2:0] addr, input logic [15:0] expected);
        dbg_addr = addr;
        #1;
        checkOutput(tag, {16'd0, dbg_data}, {16'd0, expected});
    endtask

    // Issues one instruction from an IDLE negedge and follows it to writeback
    task automatic applyStimulus(input string tag, input logic [15:0] word,
                                 input logic [15:0] expA, input logic [15:0] expB,
                                 input logic [3:0] expOp, input bit checkAB,
                                 input bit expIllegal);
        int waitCycles = 0;
        while (!instr_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!instr_ready) begin
            checkOutput({tag, "_ready_timeout"}, 0, 1);
            return;
        end
        instr_valid = 1'b1;
        instr       = word;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'hDEAD;
        checkOutput({tag, "_done_read"}, {31'd0, done}, 0);
        @(negedge clk);
        checkOutput({tag, "_done_exec"}, {31'd0, done}, 0);
        checkOutput({tag, "_op"}, {28'd0, alu_op}, {28'd0, expOp});
        if (checkAB) begin
            checkOutput({tag, "_a"}, {16'd0, alu_a}, {16'd0, expA});
            checkOutput({tag, "_b"}, {16'd0, alu_b}, {16'd0, expB});
        end
        @(negedge clk);
        checkOutput({tag, "_done_wb"}, {31'd0, done}, 1);
        checkOutput({tag, "_illegal"}, {31'd0, illegal}, {31'd0, expIllegal});
        @(negedge clk);
        checkOutput({tag, "_done_after"}, {31'd0, done}, 0);
    endtask

    initial begin
        int dones;
        int accepts;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'd0;
        dbg_addr    = 3'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {31'd0, instr_ready}, 0);
        checkOutput("rst_done", {31'd0, done}, 0);
        checkOutput("rst_zf", {31'd0, zero_flag}, 0);
        checkOutput("rst_alu_a", {16'd0, alu_a}, 0);
        checkOutput("rst_alu_op", {28'd0, alu_op}, 0);
        checkReg("rst_r1", 3'd1, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", {31'd0, instr_ready}, 1);

        applyStimulus("addi_r1", 16'h7205, 16'd0, 16'd5, 4'd7, 1'b1, 1'b0);
        checkReg("r1_is_5", 3'd1, 16'h0005);
        applyStimulus("addi_r2", 16'h7403, 16'd0, 16'd3, 4'd7, 1'b1, 1'b0);
        checkReg("r2_is_3", 3'd2, 16'h0003);
        applyStimulus("sub_r3", 16'h1650, 16'd5, 16'd3, 4'd1, 1'b1, 1'b0);
        checkReg("r3_is_2", 3'd3, 16'h0002);
        applyStimulus("slt_r4", 16'h4888, 16'd3, 16'd5, 4'd4, 1'b1, 1'b0);
        checkReg("r4_is_1", 3'd4, 16'h0001);
        applyStimulus("subi_r5", 16'h8A01, 16'd0, 16'd1, 4'd8, 1'b1, 1'b0);
        checkReg("r5_wrap", 3'd5, 16'hFFFF);
        applyStimulus("shl_r6", 16'h5C50, 16'd5, 16'd3, 4'd5, 1'b1, 1'b0);
        checkReg("r6_is_28", 3'd6, 16'h0028);
        applyStimulus("add_r0", 16'h0048, 16'd5, 16'd5, 4'd0, 1'b1, 1'b0);
        checkReg("r0_stays_0", 3'd0, 16'h0000);

        applyStimulus("cmp_eq", 16'h9E48, 16'd5, 16'd5, 4'd1, 1'b1, 1'b0);
        checkOutput("cmp_eq_zf", {31'd0, zero_flag}, 1);
        checkReg("cmp_no_wb_r7", 3'd7, 16'h0000);
        applyStimulus("cmp_ne", 16'h9650, 16'd5, 16'd3, 4'd1, 1'b1, 1'b0);
        checkOutput("cmp_ne_zf", {31'd0, zero_flag}, 0);
        checkReg("cmp_no_wb_r3", 3'd3, 16'h0002);

        applyStimulus("illegal", 16'hBE48, 16'd0, 16'd0, 4'd15, 1'b0, 1'b1);
        checkOutput("illegal_zf", {31'd0, zero_flag}, 0);
        checkReg("illegal_r7", 3'd7, 16'h0000);
        checkReg("illegal_r1", 3'd1, 16'h0005);

        applyStimulus("cmp_set", 16'h9048, 16'd5, 16'd5, 4'd1, 1'b1, 1'b0);
        checkOutput("cmp_set_zf", {31'd0, zero_flag}, 1);

        // Reset lands while ADD r7,r1,r1 is in EXEC
        instr_valid = 1'b1;
        instr       = 16'h0E48;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_op", {28'd0, alu_op}, 0);
        checkOutput("pre_rst_a", {16'd0, alu_a}, 16'd5);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_ready", {31'd0, instr_ready}, 0);
        checkOutput("mid_rst_done", {31'd0, done}, 0);
        checkOutput("mid_rst_zf", {31'd0, zero_flag}, 0);
        checkOutput("mid_rst_alu_a", {16'd0, alu_a}, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'd0, instr_ready}, 1);
        checkOutput("post_rst_done", {31'd0, done}, 0);
        checkReg("post_rst_r7", 3'd7, 16'h0000);
        checkReg("post_rst_r1", 3'd1, 16'h0000);

        // ADDI r1,r1,#1 held valid: one accept per four cycles, each sees the prior write
        dones   = 0;
        accepts = 0;
        instr_valid = 1'b1;
        instr       = 16'h7241;
        for (int i = 0; i < 8; i++) begin
            if (instr_ready) accepts++;
            @(negedge clk);
            if (done) dones++;
        end
        instr_valid = 1'b0;
        checkOutput("held_accepts", accepts, 2);
        checkOutput("held_dones", dones, 2);
        @(negedge clk);
        checkReg("held_r1", 3'd1, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got 0, expected 1");
        $fatal(1, "[TB] timeout");
    end

endmodule
